// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a 16-bit word-count header from a
// byte stream, packs big-endian 32-bit words and writes them, releasing the core when done.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [15:0] MAX_WORDS_L = 16'(MAX_WORDS);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cnt_hi_r;
    logic [7:0]  cnt_hi_s;
    logic [15:0] remaining_r;
    logic [15:0] remaining_s;
    logic [31:0] addr_r;
    logic [31:0] addr_s;
    logic [31:0] word_r;
    logic [31:0] word_s;
    logic [1:0]  byte_idx_r;
    logic [1:0]  byte_idx_s;
    logic        in_ready_r;
    logic        imem_we_r;
    logic        cpu_reset_r;
    logic        done_r;
    logic        err_r;
    logic        xfer_s;
    logic [15:0] count_s;

    // in_ready_r mirrors the current state, so a transfer never depends on in_valid feedback
    assign xfer_s  = in_valid && in_ready_r;
    assign count_s = {cnt_hi_r, in_data};

    // Next-state and datapath update decode
    always_comb begin
        state_s     = state_r;
        cnt_hi_s    = cnt_hi_r;
        remaining_s = remaining_r;
        addr_s      = addr_r;
        word_s      = word_r;
        byte_idx_s  = byte_idx_r;
        case (state_r)
            HDR_HI: begin
                if (xfer_s) begin
                    cnt_hi_s = in_data;
                    state_s  = HDR_LO;
                end else begin
                    state_s  = HDR_HI;
                end
            end
            HDR_LO: begin
                if (xfer_s) begin
                    if (count_s == 16'd0) begin
                        state_s = DONE;
                    end else if (count_s > MAX_WORDS_L) begin
                        state_s = ERR;
                    end else begin
                        remaining_s = count_s;
                        addr_s      = BASE_ADDR;
                        byte_idx_s  = 2'd0;
                        state_s     = DATA;
                    end
                end else begin
                    state_s = HDR_LO;
                end
            end
            DATA: begin
                if (xfer_s) begin
                    word_s     = {word_r[23:0], in_data};
                    byte_idx_s = byte_idx_r + 2'd1;
                    if (byte_idx_r == 2'd3) begin
                        state_s = WRITE;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            WRITE: begin
                addr_s      = addr_r + 32'd4;
                remaining_s = remaining_r - 16'd1;
                if (remaining_r == 16'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = DATA;
                end
            end
            DONE: begin
                state_s = DONE;
            end
            ERR: begin
                state_s = ERR;
            end
            default: begin
                state_s = HDR_HI;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= HDR_HI;
            cnt_hi_r    <= 8'd0;
            remaining_r <= 16'd0;
            addr_r      <= BASE_ADDR;
            word_r      <= 32'd0;
            byte_idx_r  <= 2'd0;
            in_ready_r  <= 1'b1;
            imem_we_r   <= 1'b0;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_hi_r    <= cnt_hi_s;
            remaining_r <= remaining_s;
            addr_r      <= addr_s;
            word_r      <= word_s;
            byte_idx_r  <= byte_idx_s;
            in_ready_r  <= (state_s == HDR_HI) || (state_s == HDR_LO) || (state_s == DATA);
            imem_we_r   <= (state_s == WRITE);
            cpu_reset_r <= (state_s != DONE);
            done_r      <= (state_s == DONE);
            err_r       <= (state_s == ERR);
        end
    end

    assign in_ready   = in_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = word_r;
    assign cpu_reset  = cpu_reset_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: streams images with random gaps and checks
// every cycle against a stream-level model of what the loader must do.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  byte_q[$];
    int          wr_cyc[$];
    int          done_cyc;
    int          words_wr;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks += 7;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_imem_we got %b want 0", imem_we); end
        if (imem_addr !== BASE) begin n_fail++; $display("FAIL reset_addr got %h want %h", imem_addr, BASE); end
        if (imem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset got %b want 1", cpu_reset); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        reset = 1'b0;
    endtask

    // Streams byte_q. Cycle 1 is the first driven cycle; model derived from stream rules.
    task automatic run_stream(input int gap_pct, input int gap_at, input int gap_len,
                              input int stop_writes, input int extra);
        int n_acc = 0;
        int gap_left = gap_len;
        int idle = 0;
        int cyc = 0;
        int cnt;
        int w;
        bit wr_pend = 1'b0;
        bit e_err, e_done, e_we, e_rdy, vld;
        logic [31:0] e_word;
        logic [31:0] e_addr;
        words_wr = 0;
        done_cyc = -1;
        wr_cyc.delete();
        forever begin
            @(negedge clk);
            cyc++;
            cnt    = (n_acc >= 2) ? int'({byte_q[0], byte_q[1]}) : -1;
            e_err  = (cnt > MAXW);
            e_done = (cnt == 0) || (cnt > 0 && cnt <= MAXW && words_wr == cnt);
            e_we   = wr_pend;
            e_rdy  = !e_err && !e_done && !e_we;
            n_checks += 5;
            if (in_ready !== e_rdy) begin n_fail++; $display("FAIL in_ready cyc %0d got %b want %b", cyc, in_ready, e_rdy); end
            if (imem_we !== e_we) begin n_fail++; $display("FAIL imem_we cyc %0d got %b want %b", cyc, imem_we, e_we); end
            if (done !== e_done) begin n_fail++; $display("FAIL done cyc %0d got %b want %b", cyc, done, e_done); end
            if (err !== e_err) begin n_fail++; $display("FAIL err cyc %0d got %b want %b", cyc, err, e_err); end
            if (cpu_reset !== !e_done) begin n_fail++; $display("FAIL cpu_reset cyc %0d got %b want %b", cyc, cpu_reset, !e_done); end
            if (imem_we === 1'b1) wr_cyc.push_back(cyc);
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (e_we) begin
                w = words_wr;
                e_addr = BASE + 32'(4 * w);
                e_word = {byte_q[2 + 4*w], byte_q[3 + 4*w], byte_q[4 + 4*w], byte_q[5 + 4*w]};
                n_checks += 2;
                if (imem_addr !== e_addr) begin n_fail++; $display("FAIL imem_addr word %0d got %h want %h", w, imem_addr, e_addr); end
                if (imem_wdata !== e_word) begin n_fail++; $display("FAIL imem_wdata word %0d got %h want %h", w, imem_wdata, e_word); end
                words_wr++;
                wr_pend = 1'b0;
                if (stop_writes > 0 && words_wr == stop_writes) begin
                    in_valid = 1'b0;
                    return;
                end
            end
            if (e_done || e_err) begin
                idle++;
                if (idle > extra) begin
                    in_valid = 1'b0;
                    return;
                end
            end
            if (cyc > 4000) begin
                n_fail++;
                $display("FAIL timeout cyc %0d accepted %0d bytes", cyc, n_acc);
                in_valid = 1'b0;
                return;
            end
            if (gap_left > 0 && n_acc == gap_at) begin
                vld = 1'b0;
                gap_left--;
            end else begin
                vld = ($urandom_range(99) >= gap_pct);
            end
            in_valid = vld;
            in_data  = (n_acc < byte_q.size()) ? byte_q[n_acc] : 8'($urandom);
            if (vld && e_rdy && n_acc < byte_q.size()) begin
                n_acc++;
                if (n_acc >= 6 && (n_acc - 2) % 4 == 0 && cnt >= 1 && cnt <= MAXW) wr_pend = 1'b1;
            end
        end
    endtask

    task automatic load_image(input int count, input bit ramp);
        logic [31:0] wd;
        byte_q.delete();
        byte_q.push_back(8'(count >> 8));
        byte_q.push_back(8'(count));
        for (int i = 0; i < count; i++) begin
            wd = ramp ? 32'(i) : $urandom;
            byte_q.push_back(wd[31:24]);
            byte_q.push_back(wd[23:16]);
            byte_q.push_back(wd[15:8]);
            byte_q.push_back(wd[7:0]);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        byte_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
        run_stream(0, -1, 0, 0, 5);
        n_checks += 3;
        if (wr_cyc.size() != 2) begin n_fail++; $display("FAIL basic_nwrites got %0d want 2", wr_cyc.size()); end
        if (wr_cyc.size() == 2 && (wr_cyc[0] != 7 || wr_cyc[1] != 12)) begin
            n_fail++; $display("FAIL basic_wr_cycles got %0d,%0d want 7,12", wr_cyc[0], wr_cyc[1]);
        end
        if (done_cyc != 13) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 13", done_cyc); end
    endtask

    task automatic test_gap();
        do_reset();
        byte_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
        run_stream(0, 4, 3, 0, 5);
        n_checks += 2;
        if (wr_cyc.size() != 2 || wr_cyc[0] != 10 || wr_cyc[1] != 15) begin
            n_fail++; $display("FAIL gap_wr_cycles got %0d writes want 2 at 10,15", wr_cyc.size());
        end
        if (done_cyc != 16) begin n_fail++; $display("FAIL gap_done_cycle got %0d want 16", done_cyc); end
    endtask

    task automatic test_empty();
        do_reset();
        byte_q = '{8'h00, 8'h00, 8'h12, 8'h34};
        run_stream(0, -1, 0, 0, 20);
        n_checks += 2;
        if (wr_cyc.size() != 0) begin n_fail++; $display("FAIL empty_writes got %0d want 0", wr_cyc.size()); end
        if (done_cyc != 3) begin n_fail++; $display("FAIL empty_done_cycle got %0d want 3", done_cyc); end
    endtask

    task automatic test_err();
        do_reset();
        byte_q = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_stream(0, -1, 0, 0, 20);
        n_checks += 1;
        if (wr_cyc.size() != 0) begin n_fail++; $display("FAIL err_writes got %0d want 0", wr_cyc.size()); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        load_image(3, 1'b0);
        run_stream(20, -1, 0, 2, 0);
        do_reset();
        byte_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_stream(0, -1, 0, 0, 5);
        n_checks += 2;
        if (wr_cyc.size() != 1) begin n_fail++; $display("FAIL midreset_writes got %0d want 1", wr_cyc.size()); end
        if (done_cyc < 0) begin n_fail++; $display("FAIL midreset_done got never want set"); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            do_reset();
            load_image($urandom_range(16, 1), 1'b0);
            run_stream(40, -1, 0, 0, 4);
            n_checks += 1;
            if (wr_cyc.size() != int'({byte_q[0], byte_q[1]})) begin
                n_fail++; $display("FAIL random_writes run %0d got %0d want %0d", r, wr_cyc.size(), {byte_q[0], byte_q[1]});
            end
        end
    endtask

    task automatic test_max();
        do_reset();
        load_image(MAXW, 1'b1);
        run_stream(0, -1, 0, 0, 4);
        n_checks += 2;
        if (wr_cyc.size() != MAXW) begin n_fail++; $display("FAIL max_writes got %0d want %0d", wr_cyc.size(), MAXW); end
        if (wr_cyc.size() == 0 || done_cyc != wr_cyc[$] + 1) begin
            n_fail++; $display("FAIL max_done_cycle got %0d want last write + 1", done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_empty();
        test_err();
        test_mid_reset();
        test_random();
        test_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
